// File: rtl/hv_window_monitor.sv
// hv_window_monitor: HV feedback window comparator producing debounced
// under-voltage (vn_l) and over-voltage (vn_h) flags with hysteresis,
// under-voltage blanking after switch-on, and sticky fault bits.
// Interfaces are level/strobe based: adc_valid qualifies adc_data for exactly
// the cycle it is high; there is no backpressure.
// state_dbg exposes the FSM state (0=OFF, 1=BLANK, 2=MON).
module hv_window_monitor #(
  parameter int ADC_W     = 12,
  parameter int DEB_N     = 4,
  parameter int BLANK_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] thr_low,
  input  logic [ADC_W-1:0] thr_high,
  input  logic [ADC_W-1:0] hyst,
  input  logic             vn_on,
  input  logic             clr_faults,
  output logic             vn_l,
  output logic             vn_h,
  output logic [1:0]       fault_lat,
  output logic             mon_active,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_MON   = 2'd2
  } state_t;

  localparam int BW = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC + 1);
  localparam int DW = (DEB_N < 2) ? 1 : $clog2(DEB_N + 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_N - 1);

  state_t          state, state_next;
  logic [BW-1:0]   blank_cnt;
  logic [DW-1:0]   deb_l, deb_h, deb_l_next, deb_h_next;
  logic            vn_l_next, vn_h_next;
  logic [1:0]      fault_next;

  // Window compares; the release sums are one bit wider so they never wrap.
  logic            viol_l, viol_h, rel_l, rel_h, qual_l, qual_h;
  logic            chk_l_en, chk_h_en;
  logic [ADC_W:0]  rel_l_point, rel_h_sum;

  assign viol_l      = adc_data < thr_low;
  assign viol_h      = adc_data > thr_high;
  assign rel_l_point = {1'b0, thr_low} + {1'b0, hyst};
  assign rel_h_sum   = {1'b0, adc_data} + {1'b0, hyst};
  assign rel_l       = {1'b0, adc_data} >= rel_l_point;
  assign rel_h       = rel_h_sum <= {1'b0, thr_high};
  assign qual_l      = vn_l ? rel_l : viol_l;
  assign qual_h      = vn_h ? rel_h : viol_h;
  assign chk_l_en    = vn_on && (state == ST_MON);
  assign chk_h_en    = vn_on && ((state == ST_MON) || (state == ST_BLANK));

  assign mon_active  = (state == ST_MON);
  assign state_dbg   = state;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_OFF;
    else       state <= state_next;
  end

  // FSM next-state: vn_on low always forces OFF; blanking ends as the counter hits 0.
  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:   if (vn_on) state_next = ST_BLANK;
      ST_BLANK: begin
        if (!vn_on)                       state_next = ST_OFF;
        else if (blank_cnt == BW'(1))     state_next = ST_MON;
      end
      ST_MON:   if (!vn_on) state_next = ST_OFF;
      default:  state_next = ST_OFF;
    endcase
  end

  // Blanking counter: loaded on entry to BLANK, counts down while in BLANK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_cnt <= '0;
    end else if (!vn_on) begin
      blank_cnt <= '0;
    end else if (state == ST_OFF) begin
      blank_cnt <= BLANK_LOAD;
    end else if (state == ST_BLANK && blank_cnt != '0) begin
      blank_cnt <= blank_cnt - BW'(1);
    end
  end

  // Debounce, flag toggling and sticky faults; both paths are independent.
  always_comb begin
    deb_l_next = deb_l;
    deb_h_next = deb_h;
    vn_l_next  = vn_l;
    vn_h_next  = vn_h;
    if (!vn_on) begin
      vn_l_next = 1'b0;
      vn_h_next = 1'b0;
    end
    if (!chk_l_en) begin
      deb_l_next = '0;
    end else if (adc_valid) begin
      if (!qual_l)                deb_l_next = '0;
      else if (deb_l == DEB_LAST) begin
        deb_l_next = '0;
        vn_l_next  = ~vn_l;
      end else                    deb_l_next = deb_l + DW'(1);
    end
    if (!chk_h_en) begin
      deb_h_next = '0;
    end else if (adc_valid) begin
      if (!qual_h)                deb_h_next = '0;
      else if (deb_h == DEB_LAST) begin
        deb_h_next = '0;
        vn_h_next  = ~vn_h;
      end else                    deb_h_next = deb_h + DW'(1);
    end
    // A rising flag sets its fault bit even if a clear arrives the same cycle.
    fault_next[0] = (vn_l_next & ~vn_l) | (fault_lat[0] & ~clr_faults);
    fault_next[1] = (vn_h_next & ~vn_h) | (fault_lat[1] & ~clr_faults);
  end

  // Flag, counter and fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_l     <= '0;
      deb_h     <= '0;
      vn_l      <= 1'b0;
      vn_h      <= 1'b0;
      fault_lat <= 2'b00;
    end else begin
      deb_l     <= deb_l_next;
      deb_h     <= deb_h_next;
      vn_l      <= vn_l_next;
      vn_h      <= vn_h_next;
      fault_lat <= fault_next;
    end
  end

endmodule

// File: tb/tb_hv_window_monitor.sv
// Directed bench for hv_window_monitor. Expected output vectors
// {state, vn_l, vn_h, fault_lat, mon_active} are queued as each step is
// driven and popped/compared one clock later, on the falling edge.
module tb_hv_window_monitor;
  localparam int ADC_W     = 12;
  localparam int DEB_N     = 4;
  localparam int BLANK_CYC = 16;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_MON   = 2'd2;

  logic             clk;
  logic             reset;
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic [ADC_W-1:0] thr_low;
  logic [ADC_W-1:0] thr_high;
  logic [ADC_W-1:0] hyst;
  logic             vn_on;
  logic             clr_faults;
  logic             vn_l;
  logic             vn_h;
  logic [1:0]       fault_lat;
  logic             mon_active;
  logic [1:0]       state_dbg;

  logic [6:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  hv_window_monitor #(
    .ADC_W(ADC_W), .DEB_N(DEB_N), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .thr_low(thr_low), .thr_high(thr_high), .hyst(hyst), .vn_on(vn_on),
    .clr_faults(clr_faults), .vn_l(vn_l), .vn_h(vn_h), .fault_lat(fault_lat),
    .mon_active(mon_active), .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] mk(input logic [1:0] st, input logic l, input logic h,
                                    input logic [1:0] f, input logic m);
    return {st, l, h, f, m};
  endfunction

  task automatic expect_out(input string tag, input logic [6:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [6:0] obs;
    logic [6:0] e;
    string      tag;
    obs = {state_dbg, vn_l, vn_h, fault_lat, mon_active};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: observed %b expected <queue empty>", obs);
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b (st,l,h,fault,mon)", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one cycle (sample or idle), then compare outputs after that edge.
  task automatic step(input logic v, input logic [ADC_W-1:0] d, input string tag,
                      input logic [6:0] e);
    adc_valid = v;
    adc_data  = d;
    expect_out(tag, e);
    tick();
    adc_valid = 1'b0;
    check_out();
  endtask

  int t2_data[8] = '{999, 999, 999, 1000, 999, 999, 999, 999};
  int t4_data[16] = '{3001, 3001, 3001, 3000, 3001, 3001, 3001, 3001,
                      2951, 2951, 2951, 2951, 2950, 2950, 2950, 2950};

  initial begin
    reset      = 1'b1;
    adc_data   = '0;
    adc_valid  = 1'b0;
    thr_low    = 12'd1000;
    thr_high   = 12'd3000;
    hyst       = 12'd50;
    vn_on      = 1'b0;
    clr_faults = 1'b0;
    tick();
    tick();
    expect_out("reset", mk(S_OFF, 0, 0, 2'b00, 0));
    check_out();
    reset = 1'b0;

    // T1: blanking suppresses under-voltage for 16 cycles, then 4 samples in MON.
    vn_on = 1'b1;
    for (int k = 0; k < 21; k++)
      step(1'b1, 12'd500, "t1_blank_mon",
           mk((k >= 16) ? S_MON : S_BLANK, (k >= 20), 1'b0,
              (k >= 20) ? 2'b01 : 2'b00, (k >= 16)));

    // T3: 1049 sits in the hysteresis band, 1050 releases.
    for (int k = 0; k < 4; k++)
      step(1'b1, 12'd1049, "t3_hold", mk(S_MON, 1'b1, 1'b0, 2'b01, 1'b1));
    for (int k = 0; k < 4; k++)
      step(1'b1, 12'd1050, "t3_release", mk(S_MON, (k < 3), 1'b0, 2'b01, 1'b1));

    // T2: 1000 breaks the run; idle cycles mid-run neither count nor reset.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 12'(t2_data[k]), "t2_debounce", mk(S_MON, (k == 7), 1'b0, 2'b01, 1'b1));
      if (k == 5) begin
        step(1'b0, 12'd0, "t2_idle", mk(S_MON, 1'b0, 1'b0, 2'b01, 1'b1));
        step(1'b0, 12'd0, "t2_idle", mk(S_MON, 1'b0, 1'b0, 2'b01, 1'b1));
      end
    end

    // Switch-off drops vn_l, keeps the fault bit.
    vn_on = 1'b0;
    step(1'b0, 12'd0, "off_clears_l", mk(S_OFF, 1'b0, 1'b0, 2'b01, 1'b0));

    // T4: over-voltage checked during BLANK; release completes on the MON entry edge.
    vn_on = 1'b1;
    step(1'b0, 12'd0, "t4_enter_blank", mk(S_BLANK, 1'b0, 1'b0, 2'b01, 1'b0));
    for (int k = 0; k < 16; k++)
      step(1'b1, 12'(t4_data[k]), "t4_over_blank",
           mk((k == 15) ? S_MON : S_BLANK, 1'b0, (k >= 7 && k < 15),
              (k >= 7) ? 2'b11 : 2'b01, (k == 15)));

    // T5: thr_low above thr_high so both flags rise together, then switch-off and clear.
    thr_low = 12'd3500;
    for (int k = 0; k < 4; k++)
      step(1'b1, 12'd3001, "t5_both", mk(S_MON, (k == 3), (k == 3), 2'b11, 1'b1));
    vn_on = 1'b0;
    step(1'b0, 12'd0, "t5_off", mk(S_OFF, 1'b0, 1'b0, 2'b11, 1'b0));
    clr_faults = 1'b1;
    step(1'b0, 12'd0, "t5_clr", mk(S_OFF, 1'b0, 1'b0, 2'b00, 1'b0));
    clr_faults = 1'b0;
    thr_low = 12'd1000;

    // T6: reach MON, raise vn_h with a coincident clear (set wins), count 3 releases.
    vn_on = 1'b1;
    for (int k = 0; k < 17; k++)
      step(1'b0, 12'd0, "t6_blank",
           mk((k == 16) ? S_MON : S_BLANK, 1'b0, 1'b0, 2'b00, (k == 16)));
    for (int k = 0; k < 4; k++) begin
      clr_faults = (k == 3);
      step(1'b1, 12'd3001, "t6_set_wins",
           mk(S_MON, 1'b0, (k == 3), (k == 3) ? 2'b10 : 2'b00, 1'b1));
    end
    clr_faults = 1'b0;
    for (int k = 0; k < 3; k++)
      step(1'b1, 12'd2950, "t6_count3", mk(S_MON, 1'b0, 1'b1, 2'b10, 1'b1));

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    expect_out("t6_async_reset", mk(S_OFF, 1'b0, 1'b0, 2'b00, 1'b0));
    check_out();
    tick();
    expect_out("t6_reset_held", mk(S_OFF, 1'b0, 1'b0, 2'b00, 1'b0));
    check_out();
    reset = 1'b0;

    // vn_on still high: blanking restarts from OFF for the full 16 cycles.
    for (int k = 0; k < 17; k++)
      step(1'b0, 12'd0, "t6_reblank",
           mk((k == 16) ? S_MON : S_BLANK, 1'b0, 1'b0, 2'b00, (k == 16)));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
